neureka_infeat_buffer_ctrl: RTL

Load sequencer for the latch-based input-feature buffer. It accepts a start command and a load length, then pulls words from the input streamer over a valid/ready handshake. It drives the buffer's write port (we/waddr/wdata/clear/we_all) and synthesises zero words for padded positions. It raises full_o once the buffer contents are stable, and holds them until the engine reports consumption.

---
 rtl/neureka_infeat_buffer_ctrl_if.sv | 28 ++
 rtl/neureka_infeat_buffer_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/neureka_infeat_buffer_ctrl_if.sv
// Stream-in / buffer-write bundle between the infeat load sequencer, its streamer and the latch buffer.
// Latency: none, plain wires.
// Backpressure: stream_valid_i/stream_ready_o handshake; the buffer write port is never stalled.
interface neureka_infeat_buffer_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128
);
    logic                  stream_valid_i;
    logic                  stream_ready_o;
    logic [DATA_WIDTH-1:0] stream_data_i;
    logic                  buf_we_o;
    logic                  buf_we_all_o;
    logic [ADDR_WIDTH-1:0] buf_waddr_o;
    logic [DATA_WIDTH-1:0] buf_wdata_o;
    logic                  buf_clear_o;

    // Controller side
    modport master (
        input  stream_valid_i, stream_data_i,
        output stream_ready_o, buf_we_o, buf_we_all_o, buf_waddr_o, buf_wdata_o, buf_clear_o
    );

    // Streamer + buffer side
    modport slave (
        output stream_valid_i, stream_data_i,
        input  stream_ready_o, buf_we_o, buf_we_all_o, buf_waddr_o, buf_wdata_o, buf_clear_o
    );
endinterface

// File: rtl/neureka_infeat_buffer_ctrl.sv
// Load sequencer for the latch input-feature buffer: clear, per-word load with zero padding, settle, hold full.
// Latency: write in the handshake cycle, 1 word/cycle; full_o rises two cycles after the last write.
// Backpressure: stream_ready_o only on non-padded LOAD words; streamer holds data while not ready.
// Optional broadcast load (one beat written to all words) is enabled by NEUREKA_INFEAT_CTRL_BCAST_EN.
module neureka_infeat_buffer_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WORDS  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    input  logic [NUM_WORDS-1:0]  pad_mask_i,
    input  logic                  clr_buf_i,
    input  logic                  bcast_i,
    input  logic                  consume_done_i,
    output logic                  full_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o,
    neureka_infeat_buffer_ctrl_if.master bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SETTLE, FULL} state_e;

    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(NUM_WORDS);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [NUM_WORDS-1:0]  pad_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  full_q;
    logic                  busy_q;
    logic                  bcast_act;

    logic                  ready;
    logic                  we;
    logic                  we_all;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH:0]   len_sat;
    logic                  last_word;

`ifdef NEUREKA_INFEAT_CTRL_BCAST_EN
    logic bcast_q;
    assign bcast_act = bcast_q;
`else
    logic unused_bcast;
    assign unused_bcast = bcast_i;
    assign bcast_act    = 1'b0;
`endif

    // Out-of-range lengths (0 or beyond the buffer) mean a full-depth load
    assign len_sat   = (load_len_i == '0 || load_len_i > LEN_MAX) ? LEN_MAX : load_len_i;
    assign last_word = ({1'b0, ptr_q} == (len_q - 1'b1));

    // Write port and stream-ready decode; write happens in the handshake cycle
    always_comb begin
        ready  = 1'b0;
        we     = 1'b0;
        we_all = 1'b0;
        waddr  = '0;
        wdata  = '0;
        if (!clear_i && state_q == LOAD) begin
            if (bcast_act) begin
                ready = 1'b1;
                if (bus.stream_valid_i) begin
                    we_all = 1'b1;
                    wdata  = bus.stream_data_i;
                end
            end else if (pad_q[ptr_q]) begin
                we    = 1'b1;
                waddr = ptr_q;
            end else begin
                ready = 1'b1;
                if (bus.stream_valid_i) begin
                    we    = 1'b1;
                    waddr = ptr_q;
                    wdata = bus.stream_data_i;
                end
            end
        end
    end

    assign bus.stream_ready_o = ready;
    assign bus.buf_we_o       = we;
    assign bus.buf_we_all_o   = we_all;
    assign bus.buf_waddr_o    = waddr;
    assign bus.buf_wdata_o    = wdata;
    assign bus.buf_clear_o    = clear_i || (state_q == CLEAR);

    assign full_o         = full_q;
    assign busy_o         = busy_q;
    assign words_loaded_o = cnt_q;

    // Sequencer state, word pointer, latched load config and registered status
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            pad_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef NEUREKA_INFEAT_CTRL_BCAST_EN
            bcast_q <= 1'b0;
`endif
        end else if (clear_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q   <= len_sat;
                        pad_q   <= pad_mask_i;
                        ptr_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= clr_buf_i ? CLEAR : LOAD;
`ifdef NEUREKA_INFEAT_CTRL_BCAST_EN
                        bcast_q <= bcast_i;
`endif
                    end
                end
                CLEAR: state_q <= LOAD;
                LOAD: begin
                    if (we_all) begin
                        cnt_q   <= len_q;
                        state_q <= SETTLE;
                    end else if (we) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            ptr_q   <= '0;
                            state_q <= SETTLE;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    full_q  <= 1'b1;
                    state_q <= FULL;
                end
                FULL: begin
                    if (consume_done_i) begin
                        cnt_q   <= '0;
                        full_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
